// File: rtl/calc_pkg.sv
// Shared types, ASCII constants and byte/value conversions for the calculator sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        S_OP1   = 3'd0,
        S_ECHO1 = 3'd1,
        S_OP2   = 3'd2,
        S_ECHO2 = 3'd3,
        S_OPR   = 3'd4,
        S_RES   = 3'd5
    } state_t;

    localparam logic [7:0] ASC_PLUS    = 8'h2B;
    localparam logic [7:0] ASC_MINUS   = 8'h2D;
    localparam logic [7:0] ASC_ESC     = 8'h1B;
    localparam logic [7:0] ASC_LO_BASE = 8'h30;
    localparam logic [7:0] ASC_HI_BASE = 8'h50;

    function automatic logic ascii_is_operand(input logic [7:0] b);
        return (b[7:4] == 4'h3) || (b[7:4] == 4'h5);
    endfunction

    // Upper nibble 0x5 marks the high half of the 5-bit value range.
    function automatic logic [4:0] ascii2bin(input logic [7:0] b);
        return {(b[7:4] == 4'h5), b[3:0]};
    endfunction

    function automatic logic [7:0] bin2ascii(input logic [4:0] v);
        return (v[4] ? ASC_HI_BASE : ASC_LO_BASE) | {4'h0, v[3:0]};
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational 4-bit add/subtract; result is modulo 32 with the carry/borrow in bit 4.
module calc_alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       op_sub,
    output logic [4:0] res
);

    always_comb begin
        res = op_sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Command sequencer: op1, op2, operator from UART rx; echoes operands and returns the result.
//   state   | meaning
//   S_OP1   | wait for first operand byte
//   S_ECHO1 | echo first operand when tx is free
//   S_OP2   | wait for second operand byte (timeout armed)
//   S_ECHO2 | echo second operand when tx is free
//   S_OPR   | wait for '+' / '-' (timeout armed)
//   S_RES   | send result byte, load leds
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int TO_CYCLES = 0,
    parameter int CNT_W     = 24
) (
    input  logic       clk12m,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_data_rdy,
    output logic [4:0] leds,
    output logic       err
);

    localparam logic [CNT_W-1:0] TC = CNT_W'((TO_CYCLES > 0) ? TO_CYCLES - 1 : 0);

    state_t           state, state_nxt;
    logic [3:0]       op_a, op_b, rx_nib;
    logic             rx_hi_unused;
    logic [4:0]       alu_res, res_q;
    logic             ovr_q;
    logic [CNT_W-1:0] cnt;

    logic rx_is_op, rx_is_esc, rx_is_arith;
    logic count_en, timeout;
    logic send_st, send, overrun, abort_pend;
    logic cap_op1, cap_op2, opr_ok, bad_opr, err_set;

    assign {rx_hi_unused, rx_nib} = ascii2bin(rx_data);
    assign rx_is_op    = ascii_is_operand(rx_data);
    assign rx_is_esc   = (rx_data == ASC_ESC);
    assign rx_is_arith = (rx_data == ASC_PLUS) || (rx_data == ASC_MINUS);
    assign count_en    = (TO_CYCLES > 0) && ((state == S_OP2) || (state == S_OPR));
    assign timeout     = count_en && (cnt == TC);

    calc_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .op_sub (rx_data == ASC_MINUS),
        .res    (alu_res)
    );

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) state <= S_OP1;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OP1:   if (cap_op1) state_nxt = S_ECHO1;
            S_ECHO1: if (send) state_nxt = abort_pend ? S_OP1 : S_OP2;
            S_OP2: begin
                if (timeout || (rx_data_rdy && rx_is_esc)) state_nxt = S_OP1;
                else if (cap_op2)                          state_nxt = S_ECHO2;
            end
            S_ECHO2: if (send) state_nxt = abort_pend ? S_OP1 : S_OPR;
            S_OPR: begin
                if (timeout || (rx_data_rdy && !rx_is_arith)) state_nxt = S_OP1;
                else if (opr_ok)                              state_nxt = S_RES;
            end
            S_RES:   if (send) state_nxt = S_OP1;
            default: state_nxt = S_OP1;
        endcase
    end

    always_comb begin
        send_st = 1'b0;
        cap_op1 = 1'b0;
        cap_op2 = 1'b0;
        opr_ok  = 1'b0;
        bad_opr = 1'b0;
        case (state)
            S_ECHO1, S_ECHO2, S_RES: send_st = 1'b1;
            S_OP1: cap_op1 = rx_data_rdy && rx_is_op;
            S_OP2: cap_op2 = rx_data_rdy && rx_is_op && !timeout;
            S_OPR: begin
                opr_ok  = rx_data_rdy && rx_is_arith && !timeout;
                bad_opr = rx_data_rdy && !rx_is_arith && !rx_is_esc;
            end
            default: ;
        endcase
        tx_data_rdy = send_st && !tx_busy;
        send        = tx_data_rdy;
        overrun     = send_st && rx_data_rdy;
        abort_pend  = ovr_q || overrun;
        err_set     = overrun || timeout || bad_opr;
    end

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= 8'h00;
            leds    <= 5'b00000;
            err     <= 1'b0;
            op_a    <= 4'h0;
            op_b    <= 4'h0;
            res_q   <= 5'b00000;
            ovr_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            err <= err_set;
            if (cap_op1) begin
                op_a    <= rx_nib;
                tx_data <= rx_data;
            end
            if (cap_op2) begin
                op_b    <= rx_nib;
                tx_data <= rx_data;
            end
            if (opr_ok) begin
                res_q   <= alu_res;
                tx_data <= bin2ascii(alu_res);
            end
            // An overrun turns the pending result send into a plain flush: leds keep their value.
            if (send && (state == S_RES) && !abort_pend) leds <= res_q;
            if (send)         ovr_q <= 1'b0;
            else if (overrun) ovr_q <= 1'b1;
            if (count_en && !timeout) cnt <= cnt + CNT_W'(1);
            else                      cnt <= '0;
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: directed plan items plus randomized commands.
module tb_calc_seq_ctrl;

    localparam int TO = 10;
    localparam logic [7:0] PLUS = 8'h2B, MINUS = 8'h2D, ESC = 8'h1B;

    logic       clk12m = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_rdy = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_data_rdy;
    logic [4:0] leds;
    logic       err;

    calc_seq_ctrl #(.TO_CYCLES(TO), .CNT_W(24)) dut (
        .clk12m      (clk12m),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_data_rdy (tx_data_rdy),
        .leds        (leds),
        .err         (err)
    );

    always #41 clk12m = ~clk12m;

    typedef struct packed {
        logic [7:0] data;
        logic       is_res;
        logic [4:0] leds;
    } exp_t;

    exp_t       tx_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         err_seen = 0;
    int         err_exp = 0;
    logic [4:0] model_leds = 5'b00000;
    bit         led_pending = 1'b0;
    logic [4:0] led_exp = 5'b00000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every tx strobe pops the scoreboard; result sends arm a leds check one cycle on.
    always @(negedge clk12m) begin
        exp_t e;
        if (led_pending) begin
            check("leds_after_result", 32'(leds), 32'(led_exp));
            led_pending = 1'b0;
        end
        if (tx_data_rdy === 1'b1) begin
            check("rdy_while_busy", 32'(tx_busy), 32'd0);
            if (tx_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_tx: got 0x%0h, expected no send at %0t", tx_data, $time);
            end else begin
                e = tx_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.data));
                if (e.is_res) begin
                    led_pending = 1'b1;
                    led_exp     = e.leds;
                end
            end
        end
        if (err === 1'b1) err_seen++;
    end

    function automatic int opval(input logic [7:0] b);
        return (b >= 8'h50) ? int'(b) - 'h50 : int'(b) - 'h30;
    endfunction

    function automatic logic [7:0] rand_operand();
        int v = $urandom_range(0, 31);
        return (v < 16) ? 8'(8'h30 + v) : 8'(8'h50 + v - 16);
    endfunction

    task automatic push_tx(input logic [7:0] d, input logic is_res, input logic [4:0] l);
        exp_t e;
        e.data   = d;
        e.is_res = is_res;
        e.leds   = l;
        tx_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data     = b;
        rx_data_rdy = 1'b1;
        @(posedge clk12m); #1;
        rx_data_rdy = 1'b0;
        @(posedge clk12m); #1;
        repeat (gap) begin @(posedge clk12m); #1; end
    endtask

    // One command from S_OP1; the model works on byte values, not on DUT states.
    task automatic cmd(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3, input int gap);
        int r;
        push_tx(b1, 1'b0, 5'b0);
        send_byte(b1, gap);
        if (b2 == ESC) begin
            send_byte(b2, gap);
            return;
        end
        push_tx(b2, 1'b0, 5'b0);
        send_byte(b2, gap);
        if (b3 == PLUS || b3 == MINUS) begin
            r = (b3 == PLUS) ? opval(b1) + opval(b2) : opval(b1) - opval(b2);
            r = (r + 32) % 32;
            model_leds = 5'(r);
            push_tx((r < 16) ? 8'(8'h30 + r) : 8'(8'h50 + r - 16), 1'b1, 5'(r));
        end else if (b3 != ESC) begin
            err_exp++;
        end
        send_byte(b3, gap);
    endtask

    task automatic settle(input string tag);
        repeat (4) begin @(posedge clk12m); #1; end
        check({tag, "_tx_drained"}, 32'(tx_q.size()), 32'd0);
        check({tag, "_err_count"}, 32'(err_seen), 32'(err_exp));
        check({tag, "_leds"}, 32'(leds), 32'(model_leds));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] b1, b2, b3;

        repeat (3) @(posedge clk12m);
        #1;
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_rdy", 32'(tx_data_rdy), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk12m);
        rst_n = 1'b1;
        @(posedge clk12m); #1;

        cmd("0", "4", PLUS, 0);  settle("c04p"); check("leds_04p", 32'(leds), 32'b00100);
        cmd("5", "2", MINUS, 0); settle("c52m"); check("leds_52m", 32'(leds), 32'b00011);
        cmd("2", "3", MINUS, 0); settle("c23m"); check("leds_23m", 32'(leds), 32'b11111);
        cmd("?", "?", PLUS, 0);  settle("cqqp"); check("leds_qqp", 32'(leds), 32'b11110);
        cmd("P", "1", PLUS, 0);  settle("cp1p"); check("leds_p1p", 32'(leds), 32'b00001);
        cmd("7", "1", "*", 0);   settle("c71x"); check("leds_bad_op", 32'(leds), 32'b00001);
        send_byte(8'h41, 0);
        send_byte(ESC, 0);       settle("junk");

        // echo held back while tx_busy
        tx_busy = 1'b1;
        push_tx("3", 1'b0, 5'b0);
        send_byte("3", 3);
        tx_busy = 1'b0;
        @(posedge clk12m); #1;
        push_tx("4", 1'b0, 5'b0);
        send_byte("4", 0);
        push_tx("7", 1'b1, 5'd7);
        model_leds = 5'd7;
        send_byte(PLUS, 0);
        settle("busy");

        // overrun while echo waits, then back to S_OP1
        tx_busy = 1'b1;
        push_tx("3", 1'b0, 5'b0);
        send_byte("3", 0);
        err_exp++;
        send_byte("9", 1);
        tx_busy = 1'b0;
        @(posedge clk12m); #1;
        settle("ovr");
        cmd("1", "1", PLUS, 0);  settle("post_ovr");

        // timeout after first operand
        push_tx("8", 1'b0, 5'b0);
        send_byte("8", 0);
        err_exp++;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk12m);
            if (err === 1'b1) begin n = i; break; end
        end
        check("timeout_cycle", 32'(n), 32'(TO + 1));
        settle("tmo");
        cmd("9", "5", MINUS, 0); settle("post_tmo");

        // asynchronous reset in the middle of an echo
        push_tx("6", 1'b0, 5'b0);
        rx_data = "6";
        rx_data_rdy = 1'b1;
        @(posedge clk12m); #1;
        rx_data_rdy = 1'b0;
        @(negedge clk12m); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_rdy", 32'(tx_data_rdy), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h00);
        check("mid_rst_leds", 32'(leds), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        model_leds = 5'b00000;
        #20;
        rst_n = 1'b1;
        @(posedge clk12m); #1;
        cmd("1", "1", PLUS, 0);  settle("post_rst"); check("leds_11p", 32'(leds), 32'b00010);

        for (int k = 0; k < 40; k++) begin
            int pick;
            if ($urandom_range(0, 9) == 0) send_byte(($urandom_range(0, 1) == 0) ? 8'h41 : ESC, 0);
            b1 = rand_operand();
            b2 = ($urandom_range(0, 19) == 0) ? ESC : rand_operand();
            pick = $urandom_range(0, 99);
            b3 = (pick < 45) ? PLUS : (pick < 90) ? MINUS : (pick < 95) ? 8'h2A : ESC;
            cmd(b1, b2, b3, $urandom_range(0, 3));
        end
        settle("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencer for the 4-bit add/subtract calculator datapath.
- Collects three ASCII bytes from the UART receive side: operand 1, operand 2, operator.
- Echoes each operand, runs the ALU, then returns the 5-bit result both as one ASCII byte on the UART transmit side and on the 5 LEDs.
- Sits between the UART rx/tx wrappers and the board LEDs.

Parameters:
- TO_CYCLES, 0: idle cycles allowed between bytes of one command before the sequence aborts; 0 disables the timeout.
- CNT_W, 24: width of the timeout counter; must hold TO_CYCLES.

Ports:
- clk12m in 1: 12 MHz system clock.
- rst_n in 1: asynchronous active-low reset.
- rx_data in 8: received byte; valid only while rx_data_rdy=1.
- rx_data_rdy in 1: one-cycle strobe; the byte is sampled on the clk12m rising edge while this is high.
- tx_busy in 1: transmitter cannot accept a byte this cycle.
- tx_data out 8: byte to transmit; held stable until the next send.
- tx_data_rdy out 1: one-cycle send strobe; asserted only when tx_busy=0.
- leds out 5: last result {cout, sum[3:0]}.
- err out 1: one-cycle pulse on abort (bad operator, timeout or rx overrun).

Behaviour:
- Reset values: tx_data=0x00, tx_data_rdy=0, leds=5'b00000, err=0, state=S_OP1, timeout counter=0.
- Operand decode (5-bit value):
  - 0x30..0x3F decodes to {0, byte-0x30}.
  - 0x50..0x5F decodes to {1, byte-0x50}.
  - Only bits [3:0] feed the ALU.
  - Any other byte in an operand state is ignored: no echo, state unchanged, no err.
- States and transitions:
  - S_OP1: valid operand captured -> S_ECHO1.
  - S_ECHO1: when tx_busy=0, send the captured byte -> S_OP2.
  - S_OP2: valid operand captured -> S_ECHO2.
  - S_ECHO2: when tx_busy=0, send the captured byte -> S_OPR.
  - S_OPR:
    - '+' (0x2B) or '-' (0x2D) -> S_RES.
    - Any other byte -> pulse err, return to S_OP1.
    - The operator byte is never echoed.
  - S_RES: when tx_busy=0, send the result byte and load leds in the same cycle -> S_OP1.
- Latency: a byte captured on edge N produces tx_data_rdy=1 in cycle N+1 when tx_busy=0. With rdy strobes spaced every 2 cycles, every echo and the result complete before the next strobe.
- Arithmetic (modulo 32, from the 4-bit operands zero-extended to 5 bits):
  - Addition: res = a + b.
  - Subtraction: res = a - b.
- Result byte:
  - res[4]=0: 0x30 + res[3:0].
  - res[4]=1: 0x50 + res[3:0].
- leds holds its value until the next result; it does not change on aborts.
- Overrun: rx_data_rdy=1 while in S_ECHO1, S_ECHO2 or S_RES:
  - Drop the byte, pulse err, finish the pending send, then return to S_OP1.
  - The pending send is not a result: leds are not updated.
- Escape: 0x1B in S_OP2 or S_OPR -> return to S_OP1, no err. 0x1B in S_OP1 is ignored.
- Timeout (TO_CYCLES>0):
  - Counter clears on every accepted byte.
  - Counter counts only in S_OP2 and S_OPR.
  - Reaching TO_CYCLES -> pulse err, go to S_OP1.
- Precedence: rst_n > overrun > escape/timeout > normal capture.
- Reset mid-operation clears all state immediately, asynchronously. Any partial command is lost. tx_data_rdy falls without waiting for an edge.

Decomposition:
- Package calc_pkg holds:
  - State encoding: S_OP1, S_ECHO1, S_OP2, S_ECHO2, S_OPR, S_RES.
  - ASCII constants: ASC_PLUS=0x2B, ASC_MINUS=0x2D, ASC_ESC=0x1B, ASC_LO_BASE=0x30, ASC_HI_BASE=0x50.
  - Functions ascii_is_operand, ascii2bin, bin2ascii.
- One sub-module, calc_alu (combinational, 4-bit a/b, op_sub -> 5-bit res). The controller instantiates it and registers its output into leds and tx_data.

Test Plan:
- "0","4","+" at 2-cycle spacing, tx_busy=0 -> tx bytes 0x30, 0x34, 0x34; leds=5'b00100; err never set.
- "5","2","-" -> tx 0x35, 0x32, 0x33; leds=5'b00011. Then "2","3","-" -> tx 0x32, 0x33, 0x5F; leds=5'b11111 (wrap-around).
- "?","?","+" (0x3F+0x3F) -> result 0x5E, leds=5'b11110. "P","1","+" -> echo 0x50; result 0x31, since only bits [3:0]=0 of "P" feed the ALU.
- "7","1","*" -> echoes 0x37, 0x31, then err pulse, no third tx byte, leds unchanged. Junk byte 0x41 in S_OP1 -> ignored, no tx.
- tx_busy held high 5 cycles after "3" -> echo strobe delayed until tx_busy=0. A second rx_data_rdy during the wait -> err pulse and return to S_OP1 after the echo. TO_CYCLES=10 with no byte after op1 -> err on cycle 10, S_OP1.
- rst_n low between "6" and "2" -> outputs at reset values immediately. The next "1","1","+" yields tx 0x31, 0x31, 0x32 and leds=5'b00010.
